// File: rtl/acq_trigger_ctrl.sv
// Scope acquisition sequencer: hysteresis trigger, pre/post record into a ring buffer.
// Optional `TRIG_COUNT_EN adds a saturating count of real triggers on trig_count.
module acq_trigger_ctrl #(
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 640,
    parameter int ADDR_W       = 10,
    parameter int PRETRIG      = 160,
    parameter int HYST         = 8,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              hold,
    input  logic              frame_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [2:0]        state,
    output logic              triggered,
    output logic              auto_fired
`ifdef TRIG_COUNT_EN
    ,
    output logic [15:0]       trig_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_DISPLAY = 3'd4
    } st_e;

    localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] WRAP_OFS  = ADDR_W'(DEPTH - PRETRIG);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(AUTO_TIMEOUT - 1);
    localparam logic [DATA_W-1:0] HYST_D    = DATA_W'(HYST);

    st_e               st_q;
    st_e               st_d;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic [CNT_W-1:0]  auto_cnt;
    logic              hyst_flag;
    logic [1:0]        mode_q;

    logic [DATA_W:0]   hi_sum;
    logic [DATA_W-1:0] hi_thr;
    logic [DATA_W-1:0] lo_thr;
    logic              tick_arm;
    logic              flag_hit;
    logic              level_hit;
    logic              real_trig;
    logic              auto_trig;
    logic              fire;
    logic              do_write;
    logic              leave_wait;
    logic [ADDR_W-1:0] ptr_back;

    // Thresholds saturate at the ends of the sample range
    assign hi_sum = {1'b0, trig_level} + (DATA_W+1)'(HYST);
    assign hi_thr = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
    assign lo_thr = (trig_level >= HYST_D) ? trig_level - HYST_D : '0;

    assign tick_arm  = sample_tick && (st_q == S_ARMED);
    assign flag_hit  = trig_slope ? (sample_data >= hi_thr)
                                  : (sample_data <= lo_thr);
    assign level_hit = trig_slope ? (sample_data <= trig_level)
                                  : (sample_data >= trig_level);
    assign real_trig = tick_arm && hyst_flag && level_hit;
    assign auto_trig = tick_arm && (mode_q == 2'b00) && (auto_cnt == TO_LAST);
    assign fire      = real_trig || auto_trig;
    assign do_write  = sample_tick && ((st_q == S_PREFILL) ||
                                       (st_q == S_ARMED) ||
                                       (st_q == S_POST));
    assign leave_wait = ((st_q == S_IDLE) || (st_q == S_DISPLAY)) &&
                        (st_d == S_PREFILL);
    assign ptr_back = (ptr >= PRE_OFS) ? ptr - PRE_OFS : ptr + WRAP_OFS;

    assign state     = st_q;
    assign triggered = (st_q == S_POST) || (st_q == S_DISPLAY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q <= S_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            S_IDLE: begin
                if (mode != 2'b10 || arm) begin
                    st_d = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (sample_tick && cnt == PRE_LAST) begin
                    st_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (fire) begin
                    st_d = S_POST;
                end
            end
            S_POST: begin
                if (sample_tick && cnt == POST_LAST) begin
                    st_d = S_DISPLAY;
                end
            end
            S_DISPLAY: begin
                if (frame_done && !hold) begin
                    st_d = (mode == 2'b10) ? S_IDLE : S_PREFILL;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            ptr     <= '0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_addr <= ptr;
                wr_data <= sample_data;
                ptr     <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end
        end
    end

    // cnt tracks writes within PREFILL, then within POST (trigger counts as 1)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            auto_cnt  <= '0;
            hyst_flag <= 1'b0;
            mode_q    <= 2'b00;
        end else begin
            if (leave_wait) begin
                mode_q <= mode;
            end
            if (sample_tick && st_q == S_PREFILL) begin
                cnt <= (cnt == PRE_LAST) ? '0 : cnt + 1'b1;
            end else if (fire) begin
                cnt <= ADDR_W'(1);
            end else if (sample_tick && st_q == S_POST) begin
                cnt <= (cnt == POST_LAST) ? '0 : cnt + 1'b1;
            end
            if (st_q != S_ARMED || fire) begin
                auto_cnt <= '0;
            end else if (tick_arm && mode_q == 2'b00) begin
                auto_cnt <= auto_cnt + 1'b1;
            end
            if (fire) begin
                hyst_flag <= 1'b0;
            end else if (tick_arm && flag_hit) begin
                hyst_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_addr  <= '0;
            auto_fired <= 1'b0;
        end else if (fire) begin
            trig_addr  <= ptr_back;
            auto_fired <= auto_trig && !real_trig;
        end
    end

`ifdef TRIG_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_count <= '0;
        end else if (real_trig && trig_count != 16'hFFFF) begin
            trig_count <= trig_count + 16'd1;
        end
    end
`endif

endmodule
